// File: rtl/inv_sub_bytes_seq_if.sv
// Handshake bundle for the InvSubBytes stage: upstream state input and downstream result output.
// master = the side that supplies blocks and consumes results; slave = the stage itself.
interface inv_sub_bytes_seq_if;
  // valid/ready: a transfer happens on a rising clock edge where valid and ready are both high;
  // the data word must be stable while valid is high and ready is low.
  logic         in_valid;
  logic         in_ready;
  logic [127:0] instate;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] outstate;

  modport master (
    output in_valid, instate, out_ready,
    input  in_ready, out_valid, outstate
  );

  modport slave (
    input  in_valid, instate, out_ready,
    output in_ready, out_valid, outstate
  );
endinterface

// File: rtl/inv_sub_bytes_seq.sv
// Multi-cycle AES InvSubBytes: BYTES_PER_CYCLE shared inverse S-boxes walk a 128-bit state MSB byte first.
// Optional synchronous abort port `flush` is compiled in with `define INV_SUB_BYTES_FLUSH_EN.
module inv_sub_bytes_seq #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic                clk,
  input  logic                reset,
`ifdef INV_SUB_BYTES_FLUSH_EN
  input  logic                flush,
`endif
  inv_sub_bytes_seq_if.slave  bus,
  output logic [1:0]          dbg_state
);

  localparam int NSTEPS = 16 / BYTES_PER_CYCLE;
  localparam int CW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(NSTEPS - 1);

  if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
      BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_bpc
    $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] step, step_next;
  logic [127:0]  work, work_next, sub_work;
  logic          flush_i;

`ifdef INV_SUB_BYTES_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // FIPS-197 inverse S-box, one 16-byte row per high nibble.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [127:0] row;
    row = '0;
    case (b[7:4])
      4'h0: row = 128'h52096ad53036a538bf40a39e81f3d7fb;
      4'h1: row = 128'h7ce339829b2fff87348e4344c4dee9cb;
      4'h2: row = 128'h547b9432a6c2233dee4c950b42fac34e;
      4'h3: row = 128'h082ea16628d924b2765ba2496d8bd125;
      4'h4: row = 128'h72f8f66486689816d4a45ccc5d65b692;
      4'h5: row = 128'h6c704850fdedb9da5e154657a78d9d84;
      4'h6: row = 128'h90d8ab008cbcd30af7e45805b8b34506;
      4'h7: row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
      4'h8: row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
      4'h9: row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
      4'ha: row = 128'h47f11a711d29c5896fb7620eaa18be1b;
      4'hb: row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
      4'hc: row = 128'h1fdda8338807c731b11210592780ec5f;
      4'hd: row = 128'h60517fa919b54a0d2de57a9f93c99cef;
      4'he: row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
      4'hf: row = 128'h172b047eba77d626e169146355210c7d;
      default: row = '0;
    endcase
    return row[8*(15 - int'(b[3:0])) +: 8];
  endfunction

  // Byte k of the state lives at bits [127-8k -: 8]; this step covers bytes step*BPC .. step*BPC+BPC-1.
  always_comb begin
    sub_work = work;
    for (int i = 0; i < BYTES_PER_CYCLE; i++) begin
      sub_work[8*(15 - (int'(step)*BYTES_PER_CYCLE + i)) +: 8] =
        inv_sbox(work[8*(15 - (int'(step)*BYTES_PER_CYCLE + i)) +: 8]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      step  <= '0;
      work  <= '0;
    end else begin
      state <= state_next;
      step  <= step_next;
      work  <= work_next;
    end
  end

  always_comb begin
    state_next = state;
    step_next  = step;
    work_next  = work;
    case (state)
      IDLE: begin
        if (bus.in_valid && !flush_i) begin
          work_next  = bus.instate;
          step_next  = '0;
          state_next = BUSY;
        end
      end
      BUSY: begin
        work_next = sub_work;
        if (step == LAST_STEP) begin
          step_next  = '0;
          state_next = DONE;
        end else begin
          step_next = step + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Abort wins over everything; the working register keeps its partial contents.
    if (flush_i && state != IDLE) begin
      state_next = IDLE;
      step_next  = '0;
      work_next  = work;
    end
  end

  // in_ready drops while flush is high so a blocked input is never seen as a completed transfer.
  assign bus.in_ready  = (state == IDLE) && !flush_i;
  assign bus.out_valid = (state == DONE);
  assign bus.outstate  = work;
  assign dbg_state     = state;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Self-checking bench for inv_sub_bytes_seq: directed vectors plus random blocks against a GF(2^8) reference.
// Exercises the flush port as well when INV_SUB_BYTES_FLUSH_EN is defined.
module tb_inv_sub_bytes_seq;

  localparam int BPC    = 4;
  localparam int NSTEPS = 16 / BPC;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  inv_sub_bytes_seq_if bus ();
  inv_sub_bytes_seq_if bus1 ();
  inv_sub_bytes_seq_if bus16 ();
  logic [1:0] dbg_state, dbg1, dbg16;

`ifdef INV_SUB_BYTES_FLUSH_EN
  logic flush;
  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(BPC)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus), .dbg_state(dbg_state));
  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(1)) dut1 (
    .clk(clk), .reset(reset), .flush(1'b0), .bus(bus1), .dbg_state(dbg1));
  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(16)) dut16 (
    .clk(clk), .reset(reset), .flush(1'b0), .bus(bus16), .dbg_state(dbg16));
`else
  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(BPC)) dut (
    .clk(clk), .reset(reset), .bus(bus), .dbg_state(dbg_state));
  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .dbg_state(dbg1));
  inv_sub_bytes_seq #(.BYTES_PER_CYCLE(16)) dut16 (
    .clk(clk), .reset(reset), .bus(bus16), .dbg_state(dbg16));
`endif

  int tests = 0;
  int fails = 0;
  logic [127:0] exp_q[$];
  logic [7:0]   inv_tab [256];

  localparam logic [127:0] ALL_63  = {16{8'h63}};
  localparam logic [127:0] ALL_7C  = {16{8'h7c}};
  localparam logic [127:0] ORD_IN  = {32'h007cfeff, {12{8'h63}}};
  localparam logic [127:0] ORD_OUT = {32'h52010c7d, {12{8'h00}}};

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] v);
    logic [7:0] inv;
    inv = '0;
    for (int c = 1; c < 256; c++)
      if (v != 8'h00 && gmul(v, 8'(c)) == 8'h01) inv = 8'(c);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_model(input logic [127:0] blk);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[127 - 8*k -: 8] = inv_tab[blk[127 - 8*k -: 8]];
    return r;
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offer blk, wait for acceptance, return edges from the accepting edge until out_valid.
  task automatic send_and_wait(input logic [127:0] blk, output int lat);
    int g;
    g = 0;
    while (!bus.in_ready && g < 50) begin tick(); g++; end
    check("accept_wait", 128'(g < 50), 128'(1));
    bus.instate  = blk;
    bus.in_valid = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
      if (lat == 1) begin
        bus.in_valid = 1'b0;
        bus.instate  = rand_block();
      end
    end while (!bus.out_valid && lat < 100);
    exp_q.push_back(ref_model(blk));
  endtask

  // Compare the result, hold it for `hold` cycles with out_ready low, then consume it.
  task automatic drain(input string tag, input int hold);
    logic [127:0] e;
    e = exp_q.pop_front();
    check(tag, bus.outstate, e);
    check({tag, "_inready_done"}, 128'(bus.in_ready), 128'(0));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, 128'(bus.out_valid), 128'(1));
      check({tag, "_hold_data"}, bus.outstate, e);
      check({tag, "_hold_inready"}, 128'(bus.in_ready), 128'(0));
    end
    bus.out_ready = 1'b1;
    tick();
    check({tag, "_valid_drop"}, 128'(bus.out_valid), 128'(0));
    check({tag, "_inready_back"}, 128'(bus.in_ready), 128'(1));
  endtask

  // Same block into the BPC=1 and BPC=16 instances together.
  task automatic aux_block(input logic [127:0] blk);
    int n, lat1, lat16;
    logic [127:0] out1, out16;
    n = 0; lat1 = 0; lat16 = 0; out1 = '0; out16 = '0;
    bus1.instate = blk;  bus1.in_valid = 1'b1;
    bus16.instate = blk; bus16.in_valid = 1'b1;
    do begin
      tick();
      n++;
      bus1.in_valid = 1'b0;
      bus16.in_valid = 1'b0;
      if (bus1.out_valid && lat1 == 0) begin lat1 = n; out1 = bus1.outstate; end
      if (bus16.out_valid && lat16 == 0) begin lat16 = n; out16 = bus16.outstate; end
    end while ((lat1 == 0 || lat16 == 0) && n < 60);
    check("bpc1_latency", 128'(lat1), 128'(17));
    check("bpc16_latency", 128'(lat16), 128'(2));
    check("bpc1_data", out1, ref_model(blk));
    check("bpc16_data", out16, ref_model(blk));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int lat, seen;
    logic [127:0] blk;

    reset = 1'b1;
    bus.in_valid = 1'b0; bus.instate = '0; bus.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.instate = '0; bus1.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.instate = '0; bus16.out_ready = 1'b1;
`ifdef INV_SUB_BYTES_FLUSH_EN
    flush = 1'b0;
`endif
    for (int x = 0; x < 256; x++) inv_tab[fwd_sbox(8'(x))] = 8'(x);

    #12;
    check("rst_in_ready", 128'(bus.in_ready), 128'(1));
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_outstate", bus.outstate, 128'(0));
    reset = 1'b0;
    tick();

    // all-0x63 known vector with out_ready high
    send_and_wait(ALL_63, lat);
    check("k63_latency", 128'(lat), 128'(NSTEPS + 1));
    check("k63_const", bus.outstate, 128'(0));
    drain("k63", 0);

    // byte ordering on all three widths
    send_and_wait(ORD_IN, lat);
    check("ord_latency", 128'(lat), 128'(NSTEPS + 1));
    check("ord_const", bus.outstate, ORD_OUT);
    drain("ord", 0);
    aux_block(ORD_IN);
    aux_block(rand_block());

    // backpressure for 10 cycles, then a follow-on block
    bus.out_ready = 1'b0;
    send_and_wait(rand_block(), lat);
    check("bp_latency", 128'(lat), 128'(NSTEPS + 1));
    drain("bp", 10);
    send_and_wait(rand_block(), lat);
    check("bp_next_latency", 128'(lat), 128'(NSTEPS + 1));
    drain("bp_next", 0);

    // asynchronous reset in the second BUSY cycle, between clock edges
    bus.instate = rand_block();
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    check("midrst_in_ready", 128'(bus.in_ready), 128'(1));
    check("midrst_out_valid", 128'(bus.out_valid), 128'(0));
    check("midrst_outstate", bus.outstate, 128'(0));
    reset = 1'b0;
    tick();
    send_and_wait(ALL_63, lat);
    check("postrst_latency", 128'(lat), 128'(NSTEPS + 1));
    drain("postrst", 0);

    // random blocks, random gaps and random backpressure
    for (int it = 0; it < 24; it++) begin
      int hold;
      hold = $urandom_range(0, 3);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
      bus.out_ready = (hold == 0);
      blk = rand_block();
      send_and_wait(blk, lat);
      check("rnd_latency", 128'(lat), 128'(NSTEPS + 1));
      drain("rnd", hold);
    end

`ifdef INV_SUB_BYTES_FLUSH_EN
    // flush during BUSY: back to IDLE, no result
    bus.instate = rand_block();
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_in_ready", 128'(bus.in_ready), 128'(1));
    check("flush_out_valid", 128'(bus.out_valid), 128'(0));
    seen = 0;
    for (int i = 0; i < NSTEPS + 3; i++) begin
      if (bus.out_valid) seen++;
      tick();
    end
    check("flush_no_output", 128'(seen), 128'(0));

    // flush in IDLE blocks a same-cycle offer
    bus.instate = ALL_63;
    bus.in_valid = 1'b1;
    flush = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    flush = 1'b0;
    check("flush_idle_not_taken", 128'(bus.in_ready), 128'(1));

    send_and_wait(ALL_7C, lat);
    check("flush_7c_latency", 128'(lat), 128'(NSTEPS + 1));
    check("flush_7c_const", bus.outstate, {16{8'h01}});
    drain("flush_7c", 0);
`else
    seen = 0;
    send_and_wait(ALL_7C, lat);
    check("k7c_latency", 128'(lat), 128'(NSTEPS + 1));
    check("k7c_const", bus.outstate, {16{8'h01}});
    drain("k7c", 0);
`endif

    check("scoreboard_empty", 128'(exp_q.size()), 128'(seen));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
